// File: rtl/pu_wb_sram_pkg.sv
// Shared FSM state type, address-mapping constants and the address-check helper
// for the WB SRAM responder. Address checking is enabled with WB_SRAM_ERR_CHECK_EN.
`ifndef WEIGHT_SRAM_LEN
`define WEIGHT_SRAM_LEN 64
`endif

package pu_wb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int WB_ADDR_WORD_SHIFT = 2;
    localparam int WB_LAT_CNT_W       = 4;

    // An address is bad if it is not word aligned or its word index lies beyond the bank.
    function automatic logic wbAddrBad(input logic [31:0] addr, input int depth);
        logic [31:0] wordIdx;
        wordIdx = addr >> WB_ADDR_WORD_SHIFT;
        return (addr[WB_ADDR_WORD_SHIFT-1:0] != '0) || (wordIdx >= $unsigned(depth));
    endfunction

endpackage

// File: rtl/pu_wb_sram_bank.sv
// 1R1W synchronous weight-buffer array with a registered read port.
// A read and a write to the same entry in one cycle return the old contents.
module pu_wb_sram_bank #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rd_en_i,
    input  logic                     rd_zero_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]        rd_data_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]        wr_data_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // The read register only updates on acceptance, so later writes never disturb a pending response.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            rdData_q <= rd_zero_i ? '0 : mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/pu_wb_sram_responder.sv
// WB SRAM responder: accepts one word read at a time and answers with a one-cycle
// ready pulse after READ_LATENCY cycles. Optional address checking: WB_SRAM_ERR_CHECK_EN.
module pu_wb_sram_responder
    import pu_wb_sram_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = `WEIGHT_SRAM_LEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              WB_SRAM_read,
    input  logic [31:0]       WB_SRAM_address,
    output logic [DATA_W-1:0] WB_SRAM_data,
    output logic              WB_SRAM_ready,
    input  logic              load_valid,
    input  logic [31:0]       load_address,
    input  logic [DATA_W-1:0] load_data,
    output logic [31:0]       read_count,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WB_LAT_CNT_W-1:0] LAT_INIT = WB_LAT_CNT_W'(READ_LATENCY - 1);
    localparam logic [WB_LAT_CNT_W-1:0] LAT_LAST = WB_LAT_CNT_W'(1);

    wb_state_e               state_q;
    logic [WB_LAT_CNT_W-1:0] latCnt_q;
    logic                    ready_q;
    logic [31:0]             readCount_q;

    logic             readAccept;
    logic             readBad;
    logic             loadBad;
    logic [IDX_W-1:0] readIdx;
    logic [IDX_W-1:0] loadIdx;

    assign readAccept = (state_q == IDLE) && WB_SRAM_read;
    assign readIdx    = WB_SRAM_address[WB_ADDR_WORD_SHIFT +: IDX_W];
    assign loadIdx    = load_address[WB_ADDR_WORD_SHIFT +: IDX_W];

`ifdef WB_SRAM_ERR_CHECK_EN
    logic err_q;

    assign readBad = wbAddrBad(WB_SRAM_address, DEPTH);
    assign loadBad = wbAddrBad(load_address, DEPTH);

    // Sticky: set by any flagged read acceptance or flagged load, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((readAccept && readBad) || (load_valid && loadBad)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unusedAddrBits;

    assign readBad        = 1'b0;
    assign loadBad        = 1'b0;
    assign err            = 1'b0;
    assign unusedAddrBits = ^{WB_SRAM_address[31:WB_ADDR_WORD_SHIFT+IDX_W],
                              WB_SRAM_address[WB_ADDR_WORD_SHIFT-1:0],
                              load_address[31:WB_ADDR_WORD_SHIFT+IDX_W],
                              load_address[WB_ADDR_WORD_SHIFT-1:0]};
`endif

    // Handshake FSM; ready and the response count are registered on entry to RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            latCnt_q    <= '0;
            ready_q     <= 1'b0;
            readCount_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (WB_SRAM_read) begin
                        latCnt_q <= LAT_INIT;
                        if (READ_LATENCY == 1) begin
                            state_q     <= RESP;
                            ready_q     <= 1'b1;
                            readCount_q <= readCount_q + 32'd1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    latCnt_q <= latCnt_q - LAT_LAST;
                    if (latCnt_q == LAT_LAST) begin
                        state_q     <= RESP;
                        ready_q     <= 1'b1;
                        readCount_q <= readCount_q + 32'd1;
                    end
                end
                RESP: begin
                    // The initiator still holds the finished request here, so it must not be re-accepted.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    pu_wb_sram_bank #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .rd_en_i   (readAccept),
        .rd_zero_i (readBad),
        .rd_idx_i  (readIdx),
        .rd_data_o (WB_SRAM_data),
        .wr_en_i   (load_valid && !loadBad),
        .wr_idx_i  (loadIdx),
        .wr_data_i (load_data)
    );

    assign WB_SRAM_ready = ready_q;
    assign read_count    = readCount_q;

endmodule

// File: doc/pu_wb_sram_responder.md
# pu_wb_sram_responder

Weight-buffer (WB) SRAM bank: the responder side of the WB SRAM read handshake driven by the PU WB SRAM controller. Accepts one word read at a time on `WB_SRAM_read`/`WB_SRAM_address`, returns the word on `WB_SRAM_data` with a one-cycle `WB_SRAM_ready` pulse after a fixed latency. A separate single-cycle load port fills the bank from the tile loader/DMA.

## Interface
- `DEPTH`, 1024: number of entries, power of two.
- `READ_LATENCY`, 2: cycles from request acceptance to `WB_SRAM_ready`; legal range 1..15.
- `DATA_W`, `` `WEIGHT_SRAM_LEN ``: entry width in bits.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `WB_SRAM_read` in 1: level request, held high by the initiator until `WB_SRAM_ready`.
- `WB_SRAM_address` in 32: byte address; one entry per 4-byte step.
- `WB_SRAM_data` out DATA_W: read data, valid while `WB_SRAM_ready`=1.
- `WB_SRAM_ready` out 1: one-cycle response pulse.
- `load_valid` in 1: write strobe.
- `load_address` in 32: byte address, same mapping as reads.
- `load_data` in DATA_W: write data.
- `read_count` out 32: number of completed responses, wraps at 2^32.
- `err` out 1: sticky address error (only with `WB_SRAM_ERR_CHECK_EN`).

## Operation
- Entry index = `address[2 +: $clog2(DEPTH)]`.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if `WB_SRAM_read`=1, accept the request: latch entry data into the output register, load latency counter with READ_LATENCY-1; go to RESP if READ_LATENCY=1, else WAIT.
  - WAIT: decrement counter; at 1 go to RESP. `WB_SRAM_read`/address ignored.
  - RESP: `WB_SRAM_ready`=1 for exactly this cycle; `read_count`+1; return to IDLE. `WB_SRAM_read` ignored in RESP, because the initiator still drives the old request in this cycle.
- Back-to-back requests: a request present in the cycle after RESP is accepted in IDLE, giving a throughput of one response per READ_LATENCY+1 cycles.
- Loads are always accepted, one write per cycle, in any state; no backpressure.
- Load and read acceptance on the same entry in the same cycle: the read returns the old data (read-before-write).
- Loads during WAIT/RESP do not alter the latched response data.
- Reset, including mid-transaction: FSM goes to IDLE, `WB_SRAM_ready`=0, `WB_SRAM_data`=0, `read_count`=0, `err`=0, and any in-flight request is dropped. Memory contents are not cleared.

## Timing
- Request sampled high in IDLE at edge T: `WB_SRAM_ready`=1 during cycle T+READ_LATENCY, with data from the array state at T.
- `WB_SRAM_data` holds its last value outside RESP; consumers use it only while ready=1.
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- `WB_SRAM_ERR_CHECK_EN` defined:
  - A read or load address is flagged if `address[1:0]`≠0 or `address>>2` ≥ DEPTH.
  - A flagged read still completes the full handshake but returns all-zero data.
  - A flagged load is dropped.
  - `err` is set on the acceptance cycle and stays set until reset.
- Undefined:
  - Low two bits ignored; upper bits beyond the index wrap modulo DEPTH.
  - `err` tied 0.

## Structure
- Package `pu_wb_sram_pkg`: FSM state enum (IDLE/WAIT/RESP), `WB_ADDR_WORD_SHIFT`=2, latency counter width 4.
- Sub-module `pu_wb_sram_bank`: 1R1W synchronous array, read-before-write, parameterised by DEPTH/DATA_W. The responder holds the FSM, latency counter, error check and `read_count`.

## Test plan
- READ_LATENCY=2: load 0x0010←A; read 0x0010 sampled at T → ready only at T+2, data=A, `read_count`=1.
- Initiator holds read high through RESP then issues 0x0014 (holding B) in the next cycle → exactly two ready pulses, A then B, gap of 3 cycles between pulses; no duplicate response.
- Same cycle: load 0x0020←C while read 0x0020 accepted (old D) → returns D; a subsequent read returns C.
- Reset asserted during WAIT → no ready pulse, data=0, `read_count`=0; a new request after reset completes normally.
- With the macro: read 0x0002 → ready after latency, data=0, `err`=1 and stays 1. Without the macro: the same read returns the 0x0000 entry and `err`=0.
- READ_LATENCY=1, DEPTH=1024: read 0x1000 → with the macro, `err`=1; without it, returns entry 0 (wrap).
